// File: rtl/rsa_decrypt_ctrl_if.sv
// rtl/rsa_decrypt_ctrl_if.sv - host stream and key IP signal bundle for the RSA decrypt sequencer
interface rsa_decrypt_ctrl_if #(
   parameter int WIDTH = 4
);
   logic                 in_valid;
   logic [WIDTH-1:0]     in_p;
   logic [WIDTH-1:0]     in_q;
   logic [2*WIDTH-1:0]   in_e;
   logic [2*WIDTH-1:0]   in_c;
   logic [WIDTH-1:0]     ip_p;
   logic [WIDTH-1:0]     ip_q;
   logic [2*WIDTH-1:0]   ip_e;
   logic [2*WIDTH-1:0]   ip_n;
   logic [2*WIDTH-1:0]   ip_d;
   logic                 out_valid;
   logic [2*WIDTH-1:0]   out_m;

   // host plus key IP side of the sequencer
   modport master (
      output in_valid, in_p, in_q, in_e, in_c, ip_n, ip_d,
      input  ip_p, ip_q, ip_e, out_valid, out_m
   );

   // the sequencer itself
   modport slave (
      input  in_valid, in_p, in_q, in_e, in_c, ip_n, ip_d,
      output ip_p, ip_q, ip_e, out_valid, out_m
   );
endinterface

// File: rtl/rsa_decrypt_ctrl.sv
// rtl/rsa_decrypt_ctrl.sv - captures a key and ciphertext block, runs c^D mod N per word, streams plaintext
module rsa_decrypt_ctrl #(
   parameter int WIDTH     = 4,
   parameter int NUM_WORDS = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   rsa_decrypt_ctrl_if.slave  bus
);
   localparam int W2 = 2 * WIDTH;
   localparam int W4 = 4 * WIDTH;
   localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int BW = (W2 > 1) ? $clog2(W2) : 1;
   localparam logic [CW-1:0] LAST_WORD = CW'(NUM_WORDS - 1);
   localparam logic [BW-1:0] TOP_BIT   = BW'(W2 - 1);

   typedef enum logic [2:0] {IDLE, LOAD, KEY, EXP, OUT} state_t;

   state_t          state;
   logic [W2-1:0]   cbuf [NUM_WORDS];
   logic [CW-1:0]   word;
   logic [CW-1:0]   word_nx;
   logic [BW-1:0]   bit_idx;
   logic [W2-1:0]   n_r;
   logic [W2-1:0]   d_r;
   logic [W2-1:0]   acc;
   logic [W4-1:0]   sq_full;
   logic [W4-1:0]   sq_mod;
   logic [W4-1:0]   mul_full;
   logic [W4-1:0]   mul_mod;
   logic [W2-1:0]   next_acc;
   logic            unused_hi;

   // One square-and-multiply step at full double width; a zero modulus skips reduction
   // so the datapath never divides by zero before a key has been latched.
   always_comb begin
      word_nx  = word + 1'b1;
      sq_full  = {{W2{1'b0}}, acc} * {{W2{1'b0}}, acc};
      sq_mod   = (n_r == '0) ? sq_full : (sq_full % {{W2{1'b0}}, n_r});
      mul_full = sq_mod * {{W2{1'b0}}, cbuf[word]};
      mul_mod  = (n_r == '0) ? mul_full : (mul_full % {{W2{1'b0}}, n_r});
      next_acc = d_r[bit_idx] ? mul_mod[W2-1:0] : sq_mod[W2-1:0];
   end

   assign unused_hi = &{1'b0, mul_mod[W4-1:W2]};

   // Sequencer: capture, key latch, fixed-latency exponentiation, then output burst
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         word          <= '0;
         bit_idx       <= '0;
         n_r           <= '0;
         d_r           <= '0;
         acc           <= '0;
         bus.ip_p      <= '0;
         bus.ip_q      <= '0;
         bus.ip_e      <= '0;
         bus.out_valid <= 1'b0;
         bus.out_m     <= '0;
         for (int i = 0; i < NUM_WORDS; i++) cbuf[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  bus.ip_p <= bus.in_p;
                  bus.ip_q <= bus.in_q;
                  bus.ip_e <= bus.in_e;
                  cbuf[0]  <= bus.in_c;
                  word     <= CW'(1);
                  state    <= LOAD;
               end
            end
            LOAD: begin
               if (bus.in_valid) cbuf[word] <= bus.in_c;
               // The last captured word moves us to KEY so that KEY coincides with
               // the first idle in_valid cycle; an early drop ends capture too.
               if (!bus.in_valid || word == LAST_WORD) state <= KEY;
               else word <= word_nx;
            end
            KEY: begin
               n_r     <= bus.ip_n;
               d_r     <= bus.ip_d;
               word    <= '0;
               bit_idx <= TOP_BIT;
               acc     <= W2'(1);
               state   <= EXP;
            end
            EXP: begin
               if (bit_idx == '0) begin
                  cbuf[word] <= next_acc;
                  acc        <= W2'(1);
                  bit_idx    <= TOP_BIT;
                  if (word == LAST_WORD) begin
                     bus.out_valid <= 1'b1;
                     bus.out_m     <= (word == '0) ? next_acc : cbuf[0];
                     word          <= '0;
                     state         <= OUT;
                  end else begin
                     word <= word_nx;
                  end
               end else begin
                  acc     <= next_acc;
                  bit_idx <= bit_idx - 1'b1;
               end
            end
            OUT: begin
               if (word == LAST_WORD) begin
                  bus.out_valid <= 1'b0;
                  bus.out_m     <= '0;
                  word          <= '0;
                  state         <= IDLE;
               end else begin
                  bus.out_m <= cbuf[word_nx];
                  word      <= word_nx;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rsa_decrypt_ctrl.sv
// tb/tb_rsa_decrypt_ctrl.sv - scoreboard bench for rsa_decrypt_ctrl with a behavioural key IP stub
module tb_rsa_decrypt_ctrl;
   localparam int WIDTH = 4;
   localparam int W2    = 2 * WIDTH;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic stub_d0 = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   t0;
   logic [W2-1:0] exp_q[$];
   logic [W2-1:0] exp_w;

   always #5 clk = ~clk;

   rsa_decrypt_ctrl_if #(.WIDTH(WIDTH)) bus();

   rsa_decrypt_ctrl #(.WIDTH(WIDTH), .NUM_WORDS(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // modular inverse of e modulo phi by search; 0 when none exists
   function automatic logic [W2-1:0] inv_mod(input logic [W2-1:0] e, input int phi);
      int r;
      r = 0;
      for (int d = 1; d < phi; d++)
         if (r == 0 && ((int'(e) * d) % phi) == 1) r = d;
      return W2'(r);
   endfunction

   // combinational key IP stand-in: N = P*Q, D = E^-1 mod (P-1)(Q-1), optional forced D=0
   always_comb begin
      bus.ip_n = {4'b0, bus.ip_p} * {4'b0, bus.ip_q};
      bus.ip_d = stub_d0 ? '0
                         : inv_mod(bus.ip_e, (int'(bus.ip_p) - 1) * (int'(bus.ip_q) - 1));
   end

   always @(posedge clk) cyc <= cyc + 1;

   // output monitor: pop expected words while out_valid, require out_m=0 otherwise
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         vectors++;
         assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL extra_out_valid: out_m=%0d with no expected word pending", bus.out_m);
         end
         if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            vectors++;
            assert (bus.out_m === exp_w) else begin
               miscompares++;
               $error("FAIL out_m: observed %0d expected %0d at cycle %0d", bus.out_m, exp_w, cyc);
            end
         end
      end else if (rst_n) begin
         vectors++;
         assert (bus.out_m === '0) else begin
            miscompares++;
            $error("FAIL idle_out_m: observed %0d expected 0", bus.out_m);
         end
      end
   end

   task automatic check_zero(input string tag);
      vectors++;
      assert (bus.out_valid === 1'b0) else begin
         miscompares++; $error("FAIL %s out_valid: observed %0d expected 0", tag, bus.out_valid);
      end
      vectors++;
      assert (bus.out_m === '0) else begin
         miscompares++; $error("FAIL %s out_m: observed %0d expected 0", tag, bus.out_m);
      end
      vectors++;
      assert (bus.ip_p === '0 && bus.ip_q === '0 && bus.ip_e === '0) else begin
         miscompares++;
         $error("FAIL %s ip_pqe: observed %0d/%0d/%0d expected 0/0/0", tag, bus.ip_p, bus.ip_q, bus.ip_e);
      end
   endtask

   // drive one transaction; checks key ports hold old values in the rise cycle and switch one cycle later
   task automatic send(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q, input logic [W2-1:0] e,
                       input logic [0:7][W2-1:0] c, input logic [0:7][W2-1:0] m,
                       input logic [WIDTH-1:0] op, input logic [WIDTH-1:0] oq, input logic [W2-1:0] oe,
                       output int t0_o);
      vectors++;
      assert (bus.ip_p === op && bus.ip_q === oq && bus.ip_e === oe) else begin
         miscompares++;
         $error("FAIL ip_hold: observed %0d/%0d/%0d expected %0d/%0d/%0d", bus.ip_p, bus.ip_q, bus.ip_e, op, oq, oe);
      end
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_p = (i == 0) ? p : ~p;
         bus.in_q = (i == 0) ? q : ~q;
         bus.in_e = (i == 0) ? e : ~e;
         bus.in_c = c[i];
         if (i == 0) for (int k = 0; k < 8; k++) exp_q.push_back(m[k]);
         @(posedge clk); #1;
         if (i == 0) begin
            vectors++;
            assert (bus.ip_p === p && bus.ip_q === q && bus.ip_e === e) else begin
               miscompares++;
               $error("FAIL ip_switch: observed %0d/%0d/%0d expected %0d/%0d/%0d", bus.ip_p, bus.ip_q, bus.ip_e, p, q, e);
            end
         end
      end
      bus.in_valid = 1'b0;
      bus.in_p = '0; bus.in_q = '0; bus.in_e = '0; bus.in_c = '0;
      t0_o = cyc;
   endtask

   // wait for the output burst, check its start cycle and length; returns in the idle cycle after it
   task automatic wait_out(input int t0_i);
      int  n;
      bit  seen;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      vectors++;
      assert (seen) else begin
         miscompares++; $error("FAIL out_timeout: observed no out_valid expected start at t0+65");
      end
      if (seen) begin
         vectors++;
         assert (cyc === t0_i + 65) else begin
            miscompares++; $error("FAIL out_start: observed t0+%0d expected t0+65", cyc - t0_i);
         end
         n = 0;
         while (bus.out_valid && n < 20) begin
            n++;
            @(negedge clk);
         end
         vectors++;
         assert (n === 8) else begin
            miscompares++; $error("FAIL out_len: observed %0d cycles expected 8", n);
         end
      end
   endtask

   logic [0:7][W2-1:0] c_a, m_a, c_b, m_b, ones;

   initial begin
      c_a  = {8'd2, 8'd7, 8'd0, 8'd1, 8'd14, 8'd4, 8'd8, 8'd3};
      m_a  = {8'd8, 8'd13, 8'd0, 8'd1, 8'd14, 8'd4, 8'd2, 8'd12};
      c_b  = {8'd2, 8'd3, 8'd34, 8'd1, 8'd0, 8'd6, 8'd10, 8'd35};
      m_b  = {8'd32, 8'd33, 8'd34, 8'd1, 8'd0, 8'd6, 8'd5, 8'd0};
      ones = {8{8'd1}};
      bus.in_valid = 1'b0;
      bus.in_p = '0; bus.in_q = '0; bus.in_e = '0; bus.in_c = '0;

      // power-on reset
      repeat (2) @(negedge clk);
      check_zero("por");
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // aborted transaction: reset lands in the 3rd LOAD cycle
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_p = 4'd5; bus.in_q = 4'd7; bus.in_e = 8'd5; bus.in_c = 8'(i + 20);
         if (i < 3) begin
            @(posedge clk); #1;
         end
      end
      rst_n = 1'b0;
      @(negedge clk);
      check_zero("mid_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_c = '0;
      repeat (3) @(posedge clk);
      #1;

      // clean transaction A, then B and A back-to-back
      send(4'd3, 4'd5, 8'd3, c_a, m_a, 4'd0, 4'd0, 8'd0, t0);
      wait_out(t0);
      send(4'd5, 4'd7, 8'd5, c_b, m_b, 4'd3, 4'd5, 8'd3, t0);
      wait_out(t0);
      send(4'd3, 4'd5, 8'd3, c_a, m_a, 4'd5, 4'd7, 8'd5, t0);

      // stray in_valid pulse during EXP must be ignored
      repeat (10) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_p = 4'd11; bus.in_q = 4'd13; bus.in_e = 8'd7; bus.in_c = 8'(i + 9);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.in_p = '0; bus.in_q = '0; bus.in_e = '0; bus.in_c = '0;
      vectors++;
      assert (bus.ip_p === 4'd3 && bus.ip_q === 4'd5 && bus.ip_e === 8'd3) else begin
         miscompares++;
         $error("FAIL ip_stray: observed %0d/%0d/%0d expected 3/5/3", bus.ip_p, bus.ip_q, bus.ip_e);
      end
      wait_out(t0);

      // D forced to zero by the stub: every word decrypts to 1
      stub_d0 = 1'b1;
      send(4'd3, 4'd5, 8'd3, c_a, ones, 4'd3, 4'd5, 8'd3, t0);
      wait_out(t0);
      stub_d0 = 1'b0;

      repeat (3) @(negedge clk);
      vectors++;
      assert (exp_q.size() === 0) else begin
         miscompares++; $error("FAIL leftover_words: observed %0d pending expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
